// File: rtl/pwm_8bit.sv
// 8-bit PWM: free-running 256-clock frame, registered compare output.
// PWM8_FRAME_SYNC_EN defers duty writes to the frame boundary.
module pwm_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_in,
  input  logic       duty_we,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] duty_q
);

  localparam logic [7:0] CTR_MAX = 8'hFF;

  logic [7:0] ctr;
  logic [7:0] ctr_nxt;
  logic [7:0] duty_act;
  logic [7:0] duty_act_nxt;

  assign ctr_nxt = ctr + 8'd1;
  assign duty_q  = duty_act;

`ifdef PWM8_FRAME_SYNC_EN
  logic [7:0] duty_pend;
  logic       wrap;

  assign wrap = (ctr == CTR_MAX);

  // Same-edge write bypasses the buffer so it lands in the new frame.
  always_comb begin
    duty_act_nxt = duty_act;
    if (wrap) begin
      duty_act_nxt = duty_we ? duty_in : duty_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_pend <= 8'd0;
    end else if (duty_we) begin
      duty_pend <= duty_in;
    end
  end
`else
  always_comb begin
    duty_act_nxt = duty_act;
    if (duty_we) begin
      duty_act_nxt = duty_in;
    end
  end
`endif

  // Outputs come from next-state values so they stay aligned with ctr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr         <= 8'd0;
      duty_act    <= 8'd0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ctr         <= ctr_nxt;
      duty_act    <= duty_act_nxt;
      pwm_out     <= (ctr_nxt < duty_act_nxt);
      frame_start <= (ctr_nxt == 8'd0);
    end
  end

endmodule

// File: tb/tb_pwm_8bit.sv
// Self-checking bench for pwm_8bit: per-cycle frame model plus
// directed duty scenarios with literal high-cycle counts.
module tb_pwm_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       we;
  logic       pwm_out;
  logic       frame_start;
  logic [7:0] duty_q;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int m_ctr  = 0;
  int m_act  = 0;
  int m_pend = 0;
  bit m_ran  = 0;

  pwm_8bit dut (
    .clk(clk),
    .rst(rst),
    .duty_in(din),
    .duty_we(we),
    .pwm_out(pwm_out),
    .frame_start(frame_start),
    .duty_q(duty_q)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Frame model: position in frame counts edges since reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctr  <= 0;
      m_act  <= 0;
      m_pend <= 0;
      m_ran  <= 0;
    end else begin
      m_ran <= 1;
      m_ctr <= (m_ctr + 1) % 256;
`ifdef PWM8_FRAME_SYNC_EN
      if (m_ctr == 255) m_act <= we ? int'(din) : m_pend;
      if (we) m_pend <= int'(din);
`else
      if (we) m_act <= int'(din);
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctr", int'(dut.ctr), m_ctr);
      chk("pwm_out", int'(pwm_out), int'(m_ctr < m_act));
      chk("frame_start", int'(frame_start), int'(m_ran && m_ctr == 0));
      chk("duty_q", int'(duty_q), m_act);
    end
  end

  task automatic write(input logic [7:0] v);
    we  = 1'b1;
    din = v;
    @(negedge clk);
    we  = 1'b0;
  endtask

  task automatic wait_ctr0();
    int n;
    n = 0;
    while (dut.ctr != 8'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ctr0_timeout", int'(dut.ctr), 0);
  endtask

  task automatic measure(input int wr_at, input logic [7:0] wv,
                         output int hi, output int first_low,
                         output int dq_last);
    hi = 0;
    first_low = -1;
    dq_last = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out) hi++;
      else if (first_low < 0) first_low = i;
      if (i == 255) dq_last = int'(duty_q);
      we  = (i == wr_at);
      din = wv;
      @(negedge clk);
    end
    we = 1'b0;
    if (first_low < 0) first_low = 256;
  endtask

  task automatic run_duty(input logic [7:0] v, input string tag);
    int hi, fl, dq;
    write(v);
    wait_ctr0();
    measure(-1, 8'd0, hi, fl, dq);
    chk({tag, "_high"}, hi, int'(v));
    chk({tag, "_first_low"}, fl, int'(v));
    chk({tag, "_duty_q"}, dq, int'(v));
  endtask

  initial begin
    int hi, fl, dq, fs;
    rst = 1'b1;
    we  = 1'b0;
    din = 8'd0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_ctr", int'(dut.ctr), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_fs", int'(frame_start), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_edge_ctr", int'(dut.ctr), 1);

    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm_out) hi++;
      @(negedge clk);
    end
    chk("first_frame_high", hi, 0);
    fs = 0;
    for (int i = 0; i < 512; i++) begin
      if (frame_start) fs++;
      @(negedge clk);
    end
    chk("fs_pulses_512", fs, 2);

    run_duty(8'd64, "d64");
    run_duty(8'd128, "d128");
    run_duty(8'd230, "d230");
    run_duty(8'd0, "d0");
    run_duty(8'd255, "d255");

    // Mid-frame write of 200 at ctr==100 with duty 64 active.
    write(8'd64);
    wait_ctr0();
    measure(100, 8'd200, hi, fl, dq);
`ifdef PWM8_FRAME_SYNC_EN
    chk("mid_cur_high", hi, 64);
    chk("mid_cur_duty_q", dq, 64);
`else
    chk("mid_cur_high", hi, 163);
    chk("mid_cur_duty_q", dq, 200);
`endif
    measure(-1, 8'd0, hi, fl, dq);
    chk("mid_next_high", hi, 200);

    // Write on the 255->0 edge lands in the frame starting there.
    write(8'd64);
    wait_ctr0();
    measure(255, 8'd30, hi, fl, dq);
    chk("wrap_cur_high", hi, 64);
    measure(-1, 8'd0, hi, fl, dq);
    chk("wrap_next_high", hi, 30);
    chk("wrap_next_duty_q", int'(duty_q), 30);

    // Reset mid-frame with a write still pending.
    write(8'd64);
    wait_ctr0();
    repeat (10) @(negedge clk);
    write(8'd200);
    repeat (9) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctr", int'(dut.ctr), 0);
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_duty_q", int'(duty_q), 0);
    chk("async_rst_fs", int'(frame_start), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ctr0();
    measure(-1, 8'd0, hi, fl, dq);
    chk("post_rst_high", hi, 0);
    chk("post_rst_duty_q", dq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
